// File: rtl/dmem_arb_pkg.sv
// Shared types and default widths for the data-memory port arbiter.
// The arbiter FSM state encoding lives here so the top and any future users agree on it.
package dmem_arb_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_CNT_W  = 16;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_SECOND = 1'b1
   } arb_state_e;

endpackage

// File: rtl/dmem_arb_perf_cnt.sv
// Saturating event counter used by the arbiter's optional performance monitors.
// Holds at all-ones rather than wrapping, and clears on reset.
module dmem_arb_perf_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_inc,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (i_inc && (r_count != {W{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the two slots of the dual-issue core, in program order.
// Optional perf counters are enabled with the DMEM_ARB_PERF_EN macro.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic [DATA_W-1:0] rdata1,
   output logic              stall,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_din,
   input  logic [DATA_W-1:0] mem_dout,
   output logic [CNT_W-1:0]  conflict_cnt,
   output logic [CNT_W-1:0]  merge_cnt
);

   arb_state_e        r_state;
   logic [DATA_W-1:0] r_hold;
   logic              w_both;
   logic              w_merge;
   logic              w_conflict;
   logic              w_start;

   // Two loads of the same word share one read; anything else with both slots active serialises.
   assign w_both     = req0 & req1;
   assign w_merge    = w_both & ~we0 & ~we1 & (addr0 == addr1);
   assign w_conflict = w_both & ~w_merge;
   assign w_start    = (r_state == ARB_IDLE) & w_conflict;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ARB_IDLE;
         r_hold  <= '0;
      end else begin
         case (r_state)
            ARB_IDLE: begin
               if (w_conflict) begin
                  r_hold  <= mem_dout;
                  r_state <= ARB_SECOND;
               end
            end
            default: r_state <= ARB_IDLE;
         endcase
      end
   end

   // Port mux; reset forces every output quiet so a dropped second access never reaches memory.
   always_comb begin
      stall    = 1'b0;
      mem_we   = 1'b0;
      mem_addr = '0;
      mem_din  = '0;
      rdata0   = '0;
      rdata1   = '0;
      if (rst_n) begin
         case (r_state)
            ARB_IDLE: begin
               if (req1 && !req0) begin
                  mem_we   = we1;
                  mem_addr = addr1;
                  mem_din  = wdata1;
               end else begin
                  mem_we   = we0 & req0;
                  mem_addr = addr0;
                  mem_din  = wdata0;
               end
               rdata0 = mem_dout;
               rdata1 = mem_dout;
               stall  = w_conflict;
            end
            default: begin
               mem_we   = we1 & req1;
               mem_addr = addr1;
               mem_din  = wdata1;
               rdata0   = r_hold;
               rdata1   = mem_dout;
            end
         endcase
      end
   end

`ifdef DMEM_ARB_PERF_EN
   logic w_merge_evt;

   assign w_merge_evt = (r_state == ARB_IDLE) & w_merge;

   dmem_arb_perf_cnt #(.W(CNT_W)) u_conflict_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_start),
      .o_count (conflict_cnt)
   );

   dmem_arb_perf_cnt #(.W(CNT_W)) u_merge_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_merge_evt),
      .o_count (merge_cnt)
   );
`else
   logic w_unused;

   assign w_unused     = w_start;
   assign conflict_cnt = '0;
   assign merge_cnt    = '0;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: a program-order memory model predicts load data and stall
// length per issued pair; a negedge monitor checks the port mux and pops results as pairs retire.
module tb_dmem_port_arbiter;

   logic        clk;
   logic        rst_n;
   logic        req0, we0, req1, we1;
   logic [31:0] addr0, wdata0, addr1, wdata1;
   logic [31:0] rdata0, rdata1;
   logic        stall, mem_we;
   logic [31:0] mem_addr, mem_din, mem_dout;
   logic [15:0] conflict_cnt, merge_cnt;

   logic [31:0] mem    [256];
   logic [31:0] refMem [256];

   typedef struct {
      logic [31:0] rd0;
      logic [31:0] rd1;
      bit          chk0;
      bit          chk1;
      int          stalls;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   errors = 0;
   int   nConflict = 0;
   int   nMerge = 0;
   bit   monEn = 0;
   bit   inSecond = 0;
   int   stallRun = 0;

   dmem_port_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req0         (req0),
      .we0          (we0),
      .addr0        (addr0),
      .wdata0       (wdata0),
      .rdata0       (rdata0),
      .req1         (req1),
      .we1          (we1),
      .addr1        (addr1),
      .wdata1       (wdata1),
      .rdata1       (rdata1),
      .stall        (stall),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_din      (mem_din),
      .mem_dout     (mem_dout),
      .conflict_cnt (conflict_cnt),
      .merge_cnt    (merge_cnt)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // Behavioural sram2: combinational read, write on the rising edge.
   assign mem_dout = mem[mem_addr[7:0]];
   always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_din;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic setMem(input logic [7:0] a, input logic [31:0] d);
      mem[a]    = d;
      refMem[a] = d;
   endtask

   // Issue one pair, record its predicted outcome, then wait until the pair retires.
   task automatic applyStimulus(input bit r0, input bit w0, input logic [31:0] a0, input logic [31:0] d0,
                                input bit r1, input bit w1, input logic [31:0] a1, input logic [31:0] d1);
      exp_t e;
      bit   merge;
      bit   done;
      @(posedge clk);
      #1;
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
      e = '{rd0: '0, rd1: '0, chk0: 0, chk1: 0, stalls: 0};
      merge = r0 && r1 && !w0 && !w1 && (a0 == a1);
      if (r0 && r1 && !merge) begin
         e.stalls = 1;
         nConflict++;
      end
      if (merge) nMerge++;
      if (r0) begin
         if (!w0) begin e.rd0 = refMem[a0[7:0]]; e.chk0 = 1; end
         else refMem[a0[7:0]] = d0;
      end
      if (r1) begin
         if (!w1) begin e.rd1 = refMem[a1[7:0]]; e.chk1 = 1; end
         else refMem[a1[7:0]] = d1;
      end
      if (r0 || r1) expQ.push_back(e);
      done = 0;
      for (int i = 0; i < 4 && !done; i++) begin
         @(negedge clk);
         if (!stall) done = 1;
      end
      if (!done) checkOutput("retire_timeout", 64'd0, 64'd1);
   endtask

   // Monitor: predicted port mux and stall from the live inputs, retirement compared against the queue.
   always @(negedge clk) begin
      if (monEn && rst_n) begin
         logic [31:0] eAddr, eDin;
         logic        eWe, eStall;
         exp_t        e;
         if (inSecond) begin
            eAddr = addr1; eDin = wdata1; eWe = we1 & req1; eStall = 0;
         end else begin
            if (req1 && !req0) begin
               eAddr = addr1; eDin = wdata1; eWe = we1;
            end else begin
               eAddr = addr0; eDin = wdata0; eWe = we0 & req0;
            end
            eStall = req0 && req1 && !(!we0 && !we1 && addr0 == addr1);
         end
         checkOutput("mem_addr", mem_addr, eAddr);
         checkOutput("mem_we", mem_we, eWe);
         checkOutput("mem_din", mem_din, eDin);
         checkOutput("stall", stall, eStall);
         if (stall) stallRun++;
         if ((req0 || req1) && !stall) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_retire", 64'd1, 64'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput("stall_cycles", stallRun, e.stalls);
               if (e.chk0) checkOutput("rdata0", rdata0, e.rd0);
               if (e.chk1) checkOutput("rdata1", rdata1, e.rd1);
            end
            stallRun = 0;
         end
         inSecond = eStall;
      end
   end

   task automatic idleInputs();
      req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
      req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]    = 32'hC0DE_0000 | i;
         refMem[i] = 32'hC0DE_0000 | i;
      end
      rst_n = 0;
      req0 = 1; we0 = 1; addr0 = 32'h44; wdata0 = 32'h55;
      req1 = 1; we1 = 1; addr1 = 32'h48; wdata1 = 32'h66;
      #12;
      checkOutput("rst_stall", stall, 0);
      checkOutput("rst_mem_we", mem_we, 0);
      checkOutput("rst_mem_addr", mem_addr, 0);
      checkOutput("rst_mem_din", mem_din, 0);
      checkOutput("rst_rdata0", rdata0, 0);
      checkOutput("rst_rdata1", rdata1, 0);
      checkOutput("rst_conflict_cnt", conflict_cnt, 0);
      checkOutput("rst_merge_cnt", merge_cnt, 0);
      idleInputs();
      @(negedge clk);
      rst_n = 1;

      // Reset while the second access is pending: slot-1 store must be dropped.
      setMem(8'h50, 32'h1234);
      @(posedge clk);
      #1;
      req0 = 1; we0 = 1; addr0 = 32'h48; wdata0 = 32'h77;
      req1 = 1; we1 = 1; addr1 = 32'h50; wdata1 = 32'h99;
      #1;
      checkOutput("rs_conflict_stall", stall, 1);
      @(posedge clk);
      #1;
      checkOutput("rs_second_addr", mem_addr, 32'h50);
      rst_n = 0;
      #1;
      checkOutput("rs_stall", stall, 0);
      checkOutput("rs_mem_we", mem_we, 0);
      checkOutput("rs_mem_addr", mem_addr, 0);
      idleInputs();
      @(posedge clk);
      #1;
      rst_n = 1;
      refMem[8'h48] = 32'h77;
      checkOutput("rs_store0_done", mem[8'h48], 32'h77);
      checkOutput("rs_store1_dropped", mem[8'h50], 32'h1234);
      checkOutput("rs_conflict_cnt_clr", conflict_cnt, 0);
      req0 = 1; addr0 = 32'h50;
      #1;
      checkOutput("rs_idle_stall", stall, 0);
      checkOutput("rs_idle_rdata0", rdata0, 32'h1234);
      @(posedge clk);
      #1;
      idleInputs();
      monEn = 1;

      // Directed cases.
      setMem(8'h10, 32'hAAAA);
      applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0);
      setMem(8'h04, 32'h11);
      setMem(8'h08, 32'h22);
      applyStimulus(1, 0, 32'h04, 0, 1, 0, 32'h08, 0);
      setMem(8'h20, 32'h5A);
      applyStimulus(1, 0, 32'h20, 0, 1, 0, 32'h20, 0);
      applyStimulus(1, 1, 32'h30, 32'hBEEF, 1, 0, 32'h30, 0);
      applyStimulus(1, 1, 32'h40, 32'h1, 1, 1, 32'h40, 32'h2);
      applyStimulus(0, 0, 0, 0, 1, 0, 32'h40, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

      // Randomised pairs over a small address window so collisions are common.
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
         end else begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                          32'h80 + 4 * $urandom_range(0, 7), $urandom(),
                          $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                          32'h80 + 4 * $urandom_range(0, 7), $urandom());
         end
      end

      @(posedge clk);
      #1;
      idleInputs();
      @(negedge clk);
      checkOutput("queue_empty", expQ.size(), 0);
      checkOutput("mem_40", mem[8'h40], 32'h2);
      for (int a = 8'h80; a <= 8'h9C; a += 4) begin
         checkOutput("final_mem", mem[a], refMem[a]);
      end
`ifdef DMEM_ARB_PERF_EN
      checkOutput("conflict_cnt", conflict_cnt, nConflict);
      checkOutput("merge_cnt", merge_cnt, nMerge);
`else
      checkOutput("conflict_cnt", conflict_cnt, 0);
      checkOutput("merge_cnt", merge_cnt, 0);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
